// File: rtl/display_pkg.sv
// display_pkg: shared types and helpers for the 7-segment scan blocks.
//   DIGIT_BLANK  : nibble the downstream decoder renders as all-segments-off.
//   MAX_DIGITS   : largest digit count any scanner instance supports.
//   bcd_t        : one BCD nibble.
//   onehot_digit : digit index -> one-hot enable vector (MAX_DIGITS wide).
package display_pkg;

  localparam int         MAX_DIGITS  = 8;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef logic [3:0] bcd_t;

  function automatic logic [MAX_DIGITS-1:0] onehot_digit(
    input logic [$clog2(MAX_DIGITS)-1:0] idx
  );
    logic [MAX_DIGITS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: per-digit dwell counter.
//   clk, rst_n : clock, asynchronous active-low reset.
//   en         : count enable; low clears the count so the next dwell is full.
//   tick       : high on the last cycle of a SCAN_DIV-cycle dwell.
module scan_prescaler #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pcnt;

  assign tick = en && (pcnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pcnt <= '0;
    else if (!en)    pcnt <= '0;
    else if (tick)   pcnt <= '0;
    else             pcnt <= pcnt + PW'(1);
  end

endmodule

// File: rtl/bcd_digit_scanner.sv
// bcd_digit_scanner: time-multiplexed scan controller for an N-digit
// common-segment 7-segment display.
//   clk, rst_n  : clock, asynchronous active-low reset.
//   en          : scan enable (registered into 'active').
//   load        : latch value_in into the shadow register.
//   value_in    : packed BCD, nibble i = digit i (digit 0 least significant).
//   bcd_out     : nibble of the active digit, 4'hF when idle/blanked.
//   digit_sel   : one-hot digit enable, all zero when idle.
//   digit_idx   : index of the current digit.
//   frame_done  : one-cycle pulse when the scan wraps back to digit 0.
// Optional build macro BCD_SCAN_LZB_EN enables leading-zero blanking.
// All outputs decode from registered state only.
module bcd_digit_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       value_in,
  output logic [3:0]                    bcd_out,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int XW = $clog2(MAX_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic [IW-1:0]              idx;
  logic                       active;
  logic                       frame_done_q;
  logic                       tick;
  logic                       digit_blank;
  logic [XW-1:0]              idx_ext;

  // The dwell counter only runs while a digit is actually on the display,
  // so the first digit after enable/reset gets the same SCAN_DIV cycles
  // as every other digit (active lags en by one cycle).
  scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en && active),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow       <= '0;
      idx          <= '0;
      active       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      active       <= en;
      if (load) shadow <= value_in;
      if (tick) idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      frame_done_q <= tick && (idx == LAST_IDX);
    end
  end

`ifdef BCD_SCAN_LZB_EN
  // lz[i]: nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked.
  logic [NUM_DIGITS:1]   lz;
  logic [NUM_DIGITS-1:0] blank;

  assign lz[NUM_DIGITS] = 1'b1;
  assign blank[0]       = 1'b0;

  for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_lz
    assign lz[i]    = lz[i+1] && (shadow[i] == 4'h0);
    assign blank[i] = lz[i];
  end

  assign digit_blank = blank[idx];
`else
  assign digit_blank = 1'b0;
`endif

  always_comb begin
    idx_ext          = '0;
    idx_ext[IW-1:0]  = idx;
    digit_sel        = '0;
    bcd_out          = DIGIT_BLANK;
    if (active) begin
      digit_sel = NUM_DIGITS'(onehot_digit(idx_ext));
      bcd_out   = digit_blank ? DIGIT_BLANK : shadow[idx];
    end
  end

  assign digit_idx  = idx;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// tb_bcd_digit_scanner: directed bench for bcd_digit_scanner with
// NUM_DIGITS=4, SCAN_DIV=4. Outputs are sampled on the falling edge.
module tb_bcd_digit_scanner;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_sel;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int n_chk;
  int n_fail;

  bcd_digit_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .value_in   (value_in),
    .bcd_out    (bcd_out),
    .digit_sel  (digit_sel),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check the visible digit: one-hot select, nibble and index.
  task automatic chk_digit(input string tag, input int d, input logic [3:0] nib);
    logic [3:0] sel;
    sel = 4'b0001 << d;
    chk({tag, ".sel"}, 32'(digit_sel), 32'(sel));
    chk({tag, ".bcd"}, 32'(bcd_out), 32'(nib));
    chk({tag, ".idx"}, 32'(digit_idx), d);
  endtask

  // Reset, load val with en=1, then check one full frame plus the wrap.
  // expw holds the hand-computed bcd_out per digit (nibble d = digit d).
  task automatic run_frame(input string tag, input logic [15:0] val, input logic [15:0] expw);
    int d;
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; value_in = val; load = 1'b1; en = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      d = (c / 4) % 4;
      chk_digit($sformatf("%s.c%0d", tag, c), d, expw[4*d +: 4]);
      chk($sformatf("%s.fd%0d", tag, c), 32'(frame_done), (c == 16) ? 1 : 0);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value_in = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst.bcd", 32'(bcd_out), 32'hF);
    chk("rst.sel", 32'(digit_sel), 0);
    chk("rst.idx", 32'(digit_idx), 0);
    chk("rst.fd",  32'(frame_done), 0);

    // Basic scan: 4,3,2,1 with 4-cycle dwell, frame_done on wrap.
    run_frame("scan", 16'h1234, 16'h1234);

    // Continue on digit 0 (c=17..19); its dwell ends on the next edge.
    for (int c = 17; c <= 19; c++) begin
      @(negedge clk);
      chk_digit($sformatf("scan.c%0d", c), 0, 4'h4);
      chk($sformatf("scan.fd%0d", c), 32'(frame_done), 0);
    end

    // Load coincident with the tick into digit 1: digit 1 shows new value.
    value_in = 16'h5678; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk_digit("ldtick.c0", 1, 4'h7);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk_digit($sformatf("ldtick.c%0d", c), 1, 4'h7);
    end
    @(negedge clk);
    chk_digit("gap.pre0", 2, 4'h6);
    @(negedge clk);
    chk_digit("gap.pre1", 2, 4'h6);

    // Enable gap in the middle of digit 2.
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("gap.sel%0d", c), 32'(digit_sel), 0);
      chk($sformatf("gap.bcd%0d", c), 32'(bcd_out), 32'hF);
      chk($sformatf("gap.idx%0d", c), 32'(digit_idx), 2);
    end
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_digit($sformatf("gap.post%0d", c), 2, 4'h6);
    end
    @(negedge clk);
    chk_digit("gap.next", 3, 4'h5);

    // Asynchronous reset mid-digit: outputs drop without a clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.bcd", 32'(bcd_out), 32'hF);
    chk("arst.sel", 32'(digit_sel), 0);
    chk("arst.idx", 32'(digit_idx), 0);
    chk("arst.fd",  32'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      chk_digit($sformatf("arst.re%0d", c), (c == 4) ? 1 : 0, 4'h0);
    end

    // Invalid nibbles pass through.
    run_frame("inval", 16'hA009, 16'hA009);

`ifdef BCD_SCAN_LZB_EN
    run_frame("lz70", 16'h0070, 16'hFF70);
    run_frame("lz00", 16'h0000, 16'hFFF0);
`else
    run_frame("lz70", 16'h0070, 16'h0070);
    run_frame("lz00", 16'h0000, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
